reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 152 +++++++++++++++
 tb/tb_reg_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32 x DATA_WIDTH register file with two combinational read ports,
// same-cycle write-through bypass and a registered debug read port.
// Writes are selected by a one-hot decoder output. Select 0 and select
// 32'h1 (register 0) are silently dropped. Any multi-bit select is dropped
// and raises a sticky wsel_err. wr_count counts committed writes and wraps.
module reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h1000_8000,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h7FFF_EFFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [31:0]           Wsel,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            RA1,
  input  logic [4:0]            RA2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  wsel_err,
  output logic [15:0]           wr_count
);

  // True when exactly one bit of the select vector is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Reset value of a given register index.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
    logic [DATA_WIDTH-1:0] val;
    case (idx)
      28:      val = GP_INIT;
      29:      val = SP_INIT;
      default: val = {DATA_WIDTH{1'b0}};
    endcase
    return val;
  endfunction

  // Register 0 is kept as a constant-zero entry so every index is addressable.
  logic [DATA_WIDTH-1:0] regs_r [0:31];
  logic [DATA_WIDTH-1:0] dbg_data_r;
  logic                  wsel_err_r;
  logic [15:0]           wr_count_r;

  logic                  sel_onehot_s;
  logic                  wr_legal_s;
  logic                  wr_multi_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;
  logic [DATA_WIDTH-1:0] dbg_next_s;

  // Classify the current write request: legal, multi-select error, or ignored.
  always_comb begin
    sel_onehot_s = is_onehot(Wsel);
    wr_legal_s   = 1'b0;
    wr_multi_s   = 1'b0;
    if (RegWrite) begin
      wr_legal_s = sel_onehot_s && !Wsel[0];
      wr_multi_s = (Wsel != 32'd0) && !sel_onehot_s;
    end else begin
      wr_legal_s = 1'b0;
      wr_multi_s = 1'b0;
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    rd1_s = {DATA_WIDTH{1'b0}};
    if (RA1 == 5'd0) begin
      rd1_s = {DATA_WIDTH{1'b0}};
    end else if (wr_legal_s && Wsel[RA1]) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = regs_r[RA1];
    end
  end

  // Read port 2: identical rules, fully independent of port 1.
  always_comb begin
    rd2_s = {DATA_WIDTH{1'b0}};
    if (RA2 == 5'd0) begin
      rd2_s = {DATA_WIDTH{1'b0}};
    end else if (wr_legal_s && Wsel[RA2]) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = regs_r[RA2];
    end
  end

  // Debug read uses the pre-edge contents only, so no bypass here.
  always_comb begin
    dbg_next_s = {DATA_WIDTH{1'b0}};
    if (dbg_addr == 5'd0) begin
      dbg_next_s = {DATA_WIDTH{1'b0}};
    end else begin
      dbg_next_s = regs_r[dbg_addr];
    end
  end

  // Register array: load reset values asynchronously, commit legal writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) begin
        regs_r[k] <= reset_value(k);
      end
    end else begin
      regs_r[0] <= {DATA_WIDTH{1'b0}};
      for (int k = 1; k < 32; k++) begin
        if (wr_legal_s && Wsel[k]) begin
          regs_r[k] <= WriteData;
        end
      end
    end
  end

  // Registered debug read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      dbg_data_r <= dbg_next_s;
    end
  end

  // Sticky error flag for multi-bit write selects; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wsel_err_r <= 1'b0;
    end else if (wr_multi_s) begin
      wsel_err_r <= 1'b1;
    end
  end

  // Committed-write counter, wraps silently at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_r <= 16'd0;
    end else if (wr_legal_s) begin
      wr_count_r <= wr_count_r + 16'd1;
    end
  end

  assign RD1      = rd1_s;
  assign RD2      = rd2_s;
  assign dbg_data = dbg_data_r;
  assign wsel_err = wsel_err_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank: inputs change on the falling edge,
// outputs are sampled 1 time unit after an edge.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite = 1'b0;
  logic [31:0] Wsel = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [4:0]  RA1 = 5'd0;
  logic [4:0]  RA2 = 5'd0;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic        wsel_err;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Wsel(Wsel),
    .WriteData(WriteData), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wsel_err(wsel_err),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset assertion
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RA1 = 5'd28; RA2 = 5'd29;
    #1;
    chk("rst_gp",       RD1, 32'h1000_8000);
    chk("rst_sp",       RD2, 32'h7FFF_EFFC);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_wsel_err", {31'd0, wsel_err}, 32'd0);
    chk("rst_dbg",      dbg_data, 32'd0);

    // Release reset and write reg5 on the very first edge, with bypass
    @(negedge clk);
    reset = 1'b1;
    RegWrite = 1'b1; Wsel = 32'h0000_0020; WriteData = 32'hDEAD_BEEF;
    RA1 = 5'd5; RA2 = 5'd5; dbg_addr = 5'd5;
    #1;
    chk("bypass_rd1", RD1, 32'hDEAD_BEEF);
    chk("bypass_rd2", RD2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("dbg_old_value", dbg_data, 32'd0);
    chk("wr_count_1",    {16'd0, wr_count}, 32'd1);
    @(negedge clk);
    RegWrite = 1'b0; Wsel = 32'hFFFF_FFFF; WriteData = 32'h0BAD_0BAD;
    #1;
    chk("reg5_stored", RD1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("dbg_new_value",     dbg_data, 32'hDEAD_BEEF);
    chk("rw0_no_err",        {31'd0, wsel_err}, 32'd0);
    chk("rw0_no_count",      {16'd0, wr_count}, 32'd1);

    // Wsel = 0 then Wsel = reg0: both ignored, no error
    @(negedge clk);
    RegWrite = 1'b1; Wsel = 32'h0000_0000; WriteData = 32'hFFFF_FFFF;
    RA1 = 5'd0; dbg_addr = 5'd0;
    @(negedge clk);
    Wsel = 32'h0000_0001;
    #1;
    chk("reg0_bypass_blocked", RD1, 32'd0);
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    chk("reg0_read",       RD1, 32'd0);
    chk("reg0_dbg",        dbg_data, 32'd0);
    chk("sel0_no_count",   {16'd0, wr_count}, 32'd1);
    chk("sel0_no_err",     {31'd0, wsel_err}, 32'd0);

    // Seed reg1/reg2 then issue a multi-bit select
    RegWrite = 1'b1; Wsel = 32'h0000_0002; WriteData = 32'h0000_0011;
    @(negedge clk);
    Wsel = 32'h0000_0004; WriteData = 32'h0000_0022;
    @(negedge clk);
    Wsel = 32'h0000_0006; WriteData = 32'h1234_5678;
    RA1 = 5'd1; RA2 = 5'd2;
    #1;
    chk("multi_no_bypass", RD1, 32'h0000_0011);
    chk("multi_pre_err",   {31'd0, wsel_err}, 32'd0);
    @(posedge clk); #1;
    chk("multi_err_set",   {31'd0, wsel_err}, 32'd1);
    chk("multi_reg1",      RD1, 32'h0000_0011);
    chk("multi_reg2",      RD2, 32'h0000_0022);
    chk("multi_no_count",  {16'd0, wr_count}, 32'd3);
    @(negedge clk);
    Wsel = 32'h0000_0008; WriteData = 32'h0000_0033; RA1 = 5'd3;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    chk("err_sticky",  {31'd0, wsel_err}, 32'd1);
    chk("reg3_write",  RD1, 32'h0000_0033);
    chk("count_4",     {16'd0, wr_count}, 32'd4);

    // Drive wr_count through its wrap with writes to reg31
    RA1 = 5'd31; dbg_addr = 5'd31;
    RegWrite = 1'b1; Wsel = 32'h8000_0000;
    for (int i = 0; i < 65531; i++) begin
      WriteData = i;
      @(negedge clk);
    end
    RegWrite = 1'b0;
    #1;
    chk("count_ffff", {16'd0, wr_count}, 32'h0000_FFFF);
    chk("reg31_mid",  RD1, 32'd65530);
    RegWrite = 1'b1; WriteData = 32'hCAFE_0001;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    chk("count_wrap", {16'd0, wr_count}, 32'd0);
    chk("reg31_last", RD1, 32'hCAFE_0001);
    @(posedge clk); #1;
    chk("dbg_reg31",  dbg_data, 32'hCAFE_0001);

    // Reset asserted mid-cycle with a pending write
    @(negedge clk);
    RegWrite = 1'b1; Wsel = 32'h8000_0000; WriteData = 32'h0000_0055;
    #2 reset = 1'b0;
    #1;
    chk("async_dbg",      dbg_data, 32'd0);
    chk("async_count",    {16'd0, wr_count}, 32'd0);
    chk("async_err",      {31'd0, wsel_err}, 32'd0);
    RegWrite = 1'b0;
    #1;
    chk("async_reg31",    RD1, 32'd0);
    RegWrite = 1'b1;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    #1;
    chk("rst_blocks_write", RD1, 32'd0);
    chk("rst_blocks_count", {16'd0, wr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
